// File: rtl/calc1_port_responder_if.sv
// ---------------------------------------------------------------------------
// calc1_port_responder_if
// Request/response bundle of one calc1 port.
//   req_cmd_in   [0:3]  command nibble (0 NOP, 1 ADD, 2 SUB, 5 LSH, 6 RSH)
//   req_data_in  [0:W-1] operand1 with the command cycle, operand2 next cycle
//   out_resp     [0:1]  0 none, 1 success, 2 overflow/underflow/invalid
//   out_data     [0:W-1] result, meaningful only while out_resp != 0
//   busy                high while an operation is in flight
//   req_drop            one-cycle pulse when a command could not be taken
// master: the stimulus side; slave: the responder.
// ---------------------------------------------------------------------------
interface calc1_port_responder_if #(
    parameter int DATA_WIDTH = 32
);
    logic [0:3]            req_cmd_in;
    logic [0:DATA_WIDTH-1] req_data_in;
    logic [0:1]            out_resp;
    logic [0:DATA_WIDTH-1] out_data;
    logic                  busy;
    logic                  req_drop;

    modport master (
        output req_cmd_in,
        output req_data_in,
        input  out_resp,
        input  out_data,
        input  busy,
        input  req_drop
    );

    modport slave (
        input  req_cmd_in,
        input  req_data_in,
        output out_resp,
        output out_data,
        output busy,
        output req_drop
    );
endinterface

// File: rtl/calc1_port_responder.sv
// ---------------------------------------------------------------------------
// calc1_port_responder
// Responder end of the calc1 port protocol. A request is a command plus
// operand1 on one edge and operand2 on the next; the result is returned as a
// one-cycle response LATENCY edges after the operand2 edge.
// Ports:
//   c_clk    clock, everything sampled on posedge
//   reset_n  asynchronous active-low reset
//   port     calc1_port_responder_if.slave (request in, response out)
// Parameters:
//   LATENCY     1..15, operand2 edge to response edge
//   DATA_WIDTH  operand/result width; shift amount is the low 5 bits of op2
// ---------------------------------------------------------------------------
module calc1_port_responder #(
    parameter int LATENCY    = 3,
    parameter int DATA_WIDTH = 32
) (
    input  logic                        c_clk,
    input  logic                        reset_n,
    calc1_port_responder_if.slave       port
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_OPND2 = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_LSH = 4'd5;
    localparam logic [3:0] CMD_RSH = 4'd6;

    localparam logic [1:0] RESP_OK  = 2'd1;
    localparam logic [1:0] RESP_ERR = 2'd2;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [1:0]            r_state;
    logic [3:0]            r_cnt;
    logic [3:0]            r_cmd;
    logic [DATA_WIDTH-1:0] r_op1;
    logic [DATA_WIDTH-1:0] r_result;
    logic [1:0]            r_code;
    logic [1:0]            r_resp;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_busy;
    logic                  r_drop;

    // ---------------------------------------------------------------------
    // Request side
    // ---------------------------------------------------------------------
    logic [3:0]            w_cmd;
    logic                  w_cmd_valid;
    logic [DATA_WIDTH-1:0] w_din;

    // Port vectors are [0:N] (bit 0 = MSB); copying them into [N:0] locals
    // keeps the numeric value, so op2[4:0] here is data[27:31] on the port.
    assign w_cmd       = port.req_cmd_in;
    assign w_din       = port.req_data_in;
    assign w_cmd_valid = (w_cmd != 4'd0);

    // ---------------------------------------------------------------------
    // Arithmetic: evaluated on the operand2 edge with op2 straight from the
    // bus, so only op1 and the command need to be held.
    // ---------------------------------------------------------------------
    logic [DATA_WIDTH:0]   w_sum;
    logic [4:0]            w_shamt;
    logic [1:0]            w_code;
    logic [DATA_WIDTH-1:0] w_res;

    assign w_sum   = {1'b0, r_op1} + {1'b0, w_din};
    assign w_shamt = w_din[4:0];

    always_comb begin
        w_code = RESP_ERR;
        w_res  = '0;
        case (r_cmd)
            CMD_ADD: begin
                if (!w_sum[DATA_WIDTH]) begin
                    w_code = RESP_OK;
                    w_res  = w_sum[DATA_WIDTH-1:0];
                end
            end
            CMD_SUB: begin
                if (w_din <= r_op1) begin
                    w_code = RESP_OK;
                    w_res  = r_op1 - w_din;
                end
            end
            CMD_LSH: begin
                w_code = RESP_OK;
                w_res  = r_op1 << w_shamt;
            end
            CMD_RSH: begin
                w_code = RESP_OK;
                w_res  = r_op1 >> w_shamt;
            end
            default: begin
                // invalid commands still burn the operand2 cycle, error result
                w_code = RESP_ERR;
                w_res  = '0;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Control FSM. RESP is the cycle before the response becomes visible:
    // the response is registered on the edge that leaves RESP, and that same
    // edge may take a new command, giving back-to-back spacing LATENCY+1.
    // ---------------------------------------------------------------------
    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_cmd    <= '0;
            r_op1    <= '0;
            r_result <= '0;
            r_code   <= '0;
            r_resp   <= '0;
            r_data   <= '0;
            r_busy   <= 1'b0;
            r_drop   <= 1'b0;
        end else begin
            // response and drop are single-cycle pulses
            r_resp <= '0;
            r_data <= '0;
            r_drop <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_cmd_valid) begin
                        r_cmd   <= w_cmd;
                        r_op1   <= w_din;
                        r_busy  <= 1'b1;
                        r_state <= S_OPND2;
                    end
                end

                S_OPND2: begin
                    // the command lane is not a command here; anything on it
                    // is reported as dropped and otherwise ignored
                    r_drop   <= w_cmd_valid;
                    r_result <= w_res;
                    r_code   <= w_code;
                    r_cnt    <= CNT_INIT;
                    r_state  <= (LATENCY == 1) ? S_RESP : S_WAIT;
                end

                S_WAIT: begin
                    r_drop <= w_cmd_valid;
                    r_cnt  <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= S_RESP;
                    end
                end

                S_RESP: begin
                    r_resp <= r_code;
                    r_data <= r_result;
                    if (w_cmd_valid) begin
                        r_cmd   <= w_cmd;
                        r_op1   <= w_din;
                        r_busy  <= 1'b1;
                        r_state <= S_OPND2;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign port.out_resp = r_resp;
    assign port.out_data = r_data;
    assign port.busy     = r_busy;
    assign port.req_drop = r_drop;

endmodule

// File: tb/tb_calc1_port_responder.sv
module tb_calc1_port_responder;

    localparam int LAT = 3;

    logic c_clk;
    logic reset_n;

    calc1_port_responder_if #(.DATA_WIDTH(32)) bus ();

    calc1_port_responder #(
        .LATENCY   (LAT),
        .DATA_WIDTH(32)
    ) dut (
        .c_clk  (c_clk),
        .reset_n(reset_n),
        .port   (bus)
    );

    initial c_clk = 1'b0;
    always #5 c_clk = ~c_clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // -----------------------------------------------------------------
    // Transaction-level model: one operation outstanding at most; the
    // port is free again at (accept edge + 1 + LAT). Any command arriving
    // before that is a drop.
    // -----------------------------------------------------------------
    function automatic logic [33:0] model_calc(input logic [3:0] cmd,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] s;
        case (cmd)
            4'd1: begin
                s = {32'd0, a} + {32'd0, b};
                if (s > 64'h0000_0000_FFFF_FFFF) return {2'd2, 32'd0};
                return {2'd1, s[31:0]};
            end
            4'd2: begin
                if (b > a) return {2'd2, 32'd0};
                return {2'd1, a - b};
            end
            4'd5: return {2'd1, a << (b % 32)};
            4'd6: return {2'd1, a >> (b % 32)};
            default: return {2'd2, 32'd0};
        endcase
    endfunction

    longint      e_now     = 0;
    longint      free_edge = 0;
    longint      p_acc     = 0;
    logic        p_valid   = 1'b0;
    logic [3:0]  p_cmd     = '0;
    logic [31:0] p_op1     = '0;
    logic [33:0] p_out     = '0;

    logic [1:0]  m_resp = '0;
    logic [31:0] m_data = '0;
    logic        m_busy = 1'b0;
    logic        m_drop = 1'b0;

    always @(posedge c_clk) begin
        m_resp = '0;
        m_data = '0;
        m_drop = 1'b0;
        if (!reset_n) begin
            p_valid   = 1'b0;
            free_edge = 0;
            m_busy    = 1'b0;
        end else begin
            if (p_valid && e_now == p_acc + 1)
                p_out = model_calc(p_cmd, p_op1, bus.req_data_in);
            if (p_valid && e_now == p_acc + 1 + LAT) begin
                m_resp  = p_out[33:32];
                m_data  = p_out[31:0];
                p_valid = 1'b0;
            end
            if (bus.req_cmd_in != 4'd0) begin
                if (e_now >= free_edge) begin
                    p_valid   = 1'b1;
                    p_acc     = e_now;
                    p_cmd     = bus.req_cmd_in;
                    p_op1     = bus.req_data_in;
                    free_edge = e_now + 1 + LAT;
                end else begin
                    m_drop = 1'b1;
                end
            end
            m_busy = (e_now < free_edge);
        end
        e_now++;
    end

    // Outputs change only on posedge (or async reset, applied off-negedge).
    always @(negedge c_clk) begin
        chk("model_resp", {62'd0, bus.out_resp}, {62'd0, m_resp});
        chk("model_data", {32'd0, bus.out_data}, {32'd0, m_data});
        chk("model_busy", {63'd0, bus.busy},     {63'd0, m_busy});
        chk("model_drop", {63'd0, bus.req_drop}, {63'd0, m_drop});
    end

    // -----------------------------------------------------------------
    // Stimulus helpers: inputs are set at the negedge and one posedge is
    // consumed; on return the outputs of that edge are settled.
    // -----------------------------------------------------------------
    task automatic cyc(input logic [3:0] c, input logic [31:0] d);
        bus.req_cmd_in  = c;
        bus.req_data_in = d;
        @(negedge c_clk);
    endtask

    task automatic op(input string nm, input logic [3:0] c, input logic [31:0] a,
                      input logic [31:0] b, input logic [1:0] er, input logic [31:0] ed);
        cyc(c, a);                                   // edge N
        cyc(4'd0, b);                                // edge N+1
        chk({nm, "_busy"}, {63'd0, bus.busy}, 64'd1);
        repeat (LAT - 1) cyc(4'd0, 32'd0);           // edges N+2..N+LAT
        chk({nm, "_early"}, {62'd0, bus.out_resp}, 64'd0);
        cyc(4'd0, 32'd0);                            // edge N+1+LAT
        chk({nm, "_resp"}, {62'd0, bus.out_resp}, {62'd0, er});
        chk({nm, "_data"}, {32'd0, bus.out_data}, {32'd0, ed});
        cyc(4'd0, 32'd0);
        chk({nm, "_clear"}, {62'd0, bus.out_resp}, 64'd0);
        chk({nm, "_idle"}, {63'd0, bus.busy}, 64'd0);
    endtask

    initial begin
        reset_n         = 1'b0;
        bus.req_cmd_in  = '0;
        bus.req_data_in = '0;
        repeat (2) @(negedge c_clk);
        chk("rst_resp", {62'd0, bus.out_resp}, 64'd0);
        chk("rst_data", {32'd0, bus.out_data}, 64'd0);
        chk("rst_busy", {63'd0, bus.busy},     64'd0);
        chk("rst_drop", {63'd0, bus.req_drop}, 64'd0);
        reset_n = 1'b1;
        cyc(4'd0, 32'd0);

        // T1..T4
        op("add_ok",   4'd1, 32'hFFFF0000, 32'h0000FFFF, 2'd1, 32'hFFFFFFFF);
        op("add_ovf",  4'd1, 32'h99999999, 32'h99999999, 2'd2, 32'd0);
        op("sub_unf",  4'd2, 32'd5,        32'd6,        2'd2, 32'd0);
        op("sub_eq",   4'd2, 32'd6,        32'd6,        2'd1, 32'd0);
        op("lsh1",     4'd5, 32'h00000001, 32'hFFFFFFE1, 2'd1, 32'h00000002);
        op("rsh31",    4'd6, 32'h80000000, 32'd31,       2'd1, 32'h00000001);
        op("lsh0",     4'd5, 32'h00001234, 32'h00000020, 2'd1, 32'h00001234);
        op("inv3",     4'd3, 32'd1,        32'd1,        2'd2, 32'd0);
        op("inv15",    4'd15, 32'd7,       32'd9,        2'd2, 32'd0);

        // T5: drop in WAIT, then back-to-back issue on the response edge
        cyc(4'd1, 32'd10);                           // N
        cyc(4'd0, 32'd20);                           // N+1
        cyc(4'd1, 32'd77);                           // N+2, dropped
        chk("drop_pulse", {63'd0, bus.req_drop}, 64'd1);
        cyc(4'd0, 32'd0);                            // N+3
        chk("drop_end", {63'd0, bus.req_drop}, 64'd0);
        cyc(4'd1, 32'd5);                            // N+4: response + accept
        chk("b2b_first_resp", {62'd0, bus.out_resp}, 64'd1);
        chk("b2b_first_data", {32'd0, bus.out_data}, 64'd30);
        chk("b2b_busy", {63'd0, bus.busy}, 64'd1);
        cyc(4'd0, 32'd6);                            // N+5
        cyc(4'd0, 32'd0);                            // N+6
        cyc(4'd0, 32'd0);                            // N+7
        chk("b2b_not_yet", {62'd0, bus.out_resp}, 64'd0);
        cyc(4'd0, 32'd0);                            // N+8
        chk("b2b_second_resp", {62'd0, bus.out_resp}, 64'd1);
        chk("b2b_second_data", {32'd0, bus.out_data}, 64'd11);
        cyc(4'd0, 32'd0);

        // T6: reset during WAIT abandons the operation
        cyc(4'd1, 32'd100);
        cyc(4'd0, 32'd200);
        cyc(4'd0, 32'd0);
        chk("pre_rst_busy", {63'd0, bus.busy}, 64'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("async_rst_busy", {63'd0, bus.busy},     64'd0);
        chk("async_rst_resp", {62'd0, bus.out_resp}, 64'd0);
        @(negedge c_clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc(4'd0, 32'd0);
            chk("no_ghost_resp", {62'd0, bus.out_resp}, 64'd0);
        end
        op("post_rst", 4'd1, 32'd1, 32'd2, 2'd1, 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
